// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures retired instructions {pc, instr, seq} into a small circular
//   FIFO that a trace sink drains with a valid/ready handshake. The head
//   entry is shown first-word-fall-through from registered storage. There
//   is no bypass from the commit inputs to the outputs. A commit that
//   arrives while the buffer is full, with no pop in the same cycle, is
//   dropped. Each drop sets a sticky overflow flag and bumps a saturating
//   drop counter.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   SEQ_W  width of the commit sequence number
//
// Ports
//   clk, resetn        core clock, asynchronous active-low reset
//   commit_en_i        one instruction retired this cycle
//   commit_pc_i        PC of the retiring instruction
//   commit_instr_i     encoding of the retiring instruction
//   clear_i            clears overflow_o / drop_cnt_o
//   trace_ready_i      sink takes the head entry this cycle
//   trace_valid_o      head entry present
//   trace_pc_o         head entry PC
//   trace_instr_o      head entry instruction
//   trace_seq_o        head entry sequence number
//   count_o            number of stored entries
//   overflow_o         sticky: at least one commit dropped
//   drop_cnt_o         dropped-commit count, saturating at 255
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     commit_en_i,
  input  logic [31:0]              commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic                     clear_i,
  input  logic                     trace_ready_i,
  output logic                     trace_valid_o,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic [SEQ_W-1:0]         trace_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [SEQ_W-1:0] seq_q;
  logic            ovf_q, ovf_d;
  logic [7:0]      drop_q, drop_d;
  logic            full, pop, push, drop;

  // Handshake decode. A full buffer still accepts a commit when the head
  // leaves in the same cycle, because the freed slot is reused at once.
  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = trace_valid_o && trace_ready_i;
    push = commit_en_i && (!full || pop);
    drop = commit_en_i && full && !pop;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // A drop in the same cycle as clear_i wins. In that case the counter
  // restarts at 1, not 0.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      if (clear_i)               drop_d = 8'd1;
      else if (drop_q != 8'hFF)  drop_d = drop_q + 8'd1;
    end else if (clear_i) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The sequence
  // number advances on every commit, including drops, so the sink can see
  // the gaps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (pop)         rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push)        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (commit_en_i) seq_q    <= seq_q + SEQ_W'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr_q] <= '{pc: commit_pc_i, instr: commit_instr_i, seq: seq_q};
    end
  end

  assign head          = mem[rd_ptr_q];
  assign trace_valid_o = (count_q != '0);
  assign trace_pc_o    = head.pc;
  assign trace_instr_o = head.instr;
  assign trace_seq_o   = head.seq;
  assign count_o       = count_q;
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  localparam int DEPTH = 8;
  localparam int SEQ_W = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             commit_en_i, clear_i, trace_ready_i;
  logic [31:0]      commit_pc_i, commit_instr_i;
  logic             trace_valid_o, overflow_o;
  logic [31:0]      trace_pc_o, trace_instr_o;
  logic [SEQ_W-1:0] trace_seq_o;
  logic [3:0]       count_o;
  logic [7:0]       drop_cnt_o;

  int checks = 0;
  int errors = 0;

  commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .resetn(resetn),
    .commit_en_i(commit_en_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .clear_i(clear_i),
    .trace_ready_i(trace_ready_i), .trace_valid_o(trace_valid_o),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_seq_o(trace_seq_o), .count_o(count_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
    commit_en_i    = 1'b1;
    commit_pc_i    = pc;
    commit_instr_i = instr;
  endtask

  // Pulse reset between edges. Check the asynchronous clear, then release.
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    commit_en_i = 1'b0; clear_i = 1'b0; trace_ready_i = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(trace_valid_o), 32'd0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_pc"},    trace_pc_o, 32'd0);
    chk({tag, "_instr"}, trace_instr_o, 32'd0);
    chk({tag, "_seq"},   32'(trace_seq_o), 32'd0);
    chk({tag, "_ovf"},   32'(overflow_o), 32'd0);
    chk({tag, "_drop"},  32'(drop_cnt_o), 32'd0);
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; commit_en_i = 1'b0; clear_i = 1'b0; trace_ready_i = 1'b0;
    commit_pc_i = '0; commit_instr_i = '0;
    #2;
    do_reset("rst0");

    // Basic passthrough. The buffer is empty, so a commit must not show up
    // before the edge.
    trace_ready_i = 1'b1;
    commit(32'h8000_0000, 32'h0000_0013);
    #1;
    chk("pt_nobypass_valid", 32'(trace_valid_o), 32'd0);
    step();
    commit_en_i = 1'b0;
    chk("pt_valid", 32'(trace_valid_o), 32'd1);
    chk("pt_pc",    trace_pc_o, 32'h8000_0000);
    chk("pt_instr", trace_instr_o, 32'h0000_0013);
    chk("pt_seq",   32'(trace_seq_o), 32'd0);
    step();
    chk("pt_empty_valid", 32'(trace_valid_o), 32'd0);
    chk("pt_empty_count", 32'(count_o), 32'd0);

    // Fill and overflow: 10 commits into 8 slots with no sink.
    do_reset("rst1");
    for (int i = 0; i < 10; i++) begin
      commit(32'h1000 + 32'(i) * 4, 32'(i));
      step();
    end
    commit_en_i = 1'b0;
    chk("fill_count", 32'(count_o), 32'd8);
    chk("fill_ovf",   32'(overflow_o), 32'd1);
    chk("fill_drop",  32'(drop_cnt_o), 32'd2);
    chk("fill_seq",   32'(trace_seq_o), 32'd0);
    step();
    chk("stall_pc",  trace_pc_o, 32'h1000);
    chk("stall_seq", 32'(trace_seq_o), 32'd0);
    trace_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(trace_valid_o), 32'd1);
      chk("drain_seq",   32'(trace_seq_o), 32'(i));
      chk("drain_pc",    trace_pc_o, 32'h1000 + 32'(i) * 4);
      step();
    end
    chk("drain_done_valid", 32'(trace_valid_o), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow_o), 32'd1);

    // Full buffer with a push and a pop in the same cycle.
    do_reset("rst2");
    for (int i = 0; i < 8; i++) begin
      commit(32'h2000 + 32'(i) * 4, 32'(i));
      step();
    end
    commit(32'hABCD_0000, 32'h1234_5678);
    trace_ready_i = 1'b1;
    step();
    commit_en_i = 1'b0;
    chk("fpp_count", 32'(count_o), 32'd8);
    chk("fpp_ovf",   32'(overflow_o), 32'd0);
    chk("fpp_drop",  32'(drop_cnt_o), 32'd0);
    chk("fpp_head",  32'(trace_seq_o), 32'd1);
    for (int k = 1; k < 8; k++) begin
      chk("fpp_seq", 32'(trace_seq_o), 32'(k));
      step();
    end
    chk("fpp_new_pc",    trace_pc_o, 32'hABCD_0000);
    chk("fpp_new_instr", trace_instr_o, 32'h1234_5678);
    chk("fpp_new_seq",   32'(trace_seq_o), 32'd8);
    chk("fpp_new_count", 32'(count_o), 32'd1);

    // A clear that collides with a drop, then a clear on its own.
    do_reset("rst3");
    for (int i = 0; i < 13; i++) begin
      commit(32'(i), 32'(i));
      step();
    end
    chk("clr_pre_ovf",  32'(overflow_o), 32'd1);
    chk("clr_pre_drop", 32'(drop_cnt_o), 32'd5);
    clear_i = 1'b1;
    step();
    commit_en_i = 1'b0;
    chk("clr_col_ovf",  32'(overflow_o), 32'd1);
    chk("clr_col_drop", 32'(drop_cnt_o), 32'd1);
    step();
    clear_i = 1'b0;
    chk("clr_ovf",   32'(overflow_o), 32'd0);
    chk("clr_drop",  32'(drop_cnt_o), 32'd0);
    chk("clr_count", 32'(count_o), 32'd8);
    chk("clr_head",  32'(trace_seq_o), 32'd0);

    // Sequence wrap with 4-bit sequence numbers.
    do_reset("rst4");
    trace_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      commit(32'(i), 32'(i));
      step();
      chk("wrap_seq",   32'(trace_seq_o), 32'(i % 16));
      chk("wrap_pc",    trace_pc_o, 32'(i));
      chk("wrap_count", 32'(count_o), 32'd1);
    end
    commit_en_i = 1'b0;
    step();
    chk("wrap_empty", 32'(count_o), 32'd0);

    // Drop counter saturation: 8 fills, then 300 drops.
    trace_ready_i = 1'b0;
    for (int i = 0; i < 308; i++) begin
      commit(32'(i), 32'(i));
      step();
      if (i == 261) chk("sat_254", 32'(drop_cnt_o), 32'd254);
      if (i == 262) chk("sat_255", 32'(drop_cnt_o), 32'd255);
    end
    commit_en_i = 1'b0;
    chk("sat_final", 32'(drop_cnt_o), 32'd255);
    chk("sat_ovf",   32'(overflow_o), 32'd1);

    // Reset asserted mid-stream, between edges.
    do_reset("rst5");
    for (int i = 0; i < 5; i++) begin
      commit(32'h5000 + 32'(i), 32'(i));
      step();
    end
    commit_en_i = 1'b0;
    chk("mid_count", 32'(count_o), 32'd5);
    #2;
    do_reset("mid_rst");
    commit(32'h3000, 32'h0000_0033);
    step();
    commit_en_i = 1'b0;
    chk("post_count", 32'(count_o), 32'd1);
    chk("post_pc",    trace_pc_o, 32'h3000);
    chk("post_seq",   32'(trace_seq_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
